// File: rtl/id_fetch_rx.sv
// rtl/id_fetch_rx.sv - IF->ID receiver: ID slot register, stall/redirect/trap control.
// Optional macro BRANCH_FLUSH_EN: taken branches flush instead of issuing a delay slot.
module id_fetch_rx #(
  parameter int unsigned WARMUP       = 2,
  parameter int unsigned REDIRECT_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_in,
  input  logic [31:0] i_inst_in,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_ex_stall,
  output logic        o_hold_if,
  output logic        o_br,
  output logic [31:0] o_pc_branch,
  output logic        o_except,
  output logic [31:0] o_epc,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst
);

  typedef enum logic [1:0] {S_WARM, S_RUN, S_FLUSH} state_t;

  localparam state_t     S_RESET = (WARMUP == 0) ? S_RUN : S_WARM;
  localparam logic [7:0] C_WARM  = 8'(WARMUP);
  localparam logic [7:0] C_RDL   = 8'(REDIRECT_LAT);
`ifndef BRANCH_FLUSH_EN
  localparam logic [7:0] C_RDL_SLOT = (REDIRECT_LAT > 0) ? 8'(REDIRECT_LAT - 1) : 8'd0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt, w_cnt_nx;
`ifndef BRANCH_FLUSH_EN
  logic       r_pend, w_pend_nx;
`endif

  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt;
  logic        w_legal, w_reads_rt, w_hazard, w_taken, w_is_jump;
  logic [31:0] w_br_tgt, w_j_tgt;
  logic        w_run, w_trap, w_bubble, w_issue;

  // Instruction decode
  assign w_op = i_inst_in[31:26];
  assign w_rs = i_inst_in[25:21];
  assign w_rt = i_inst_in[20:16];

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
      6'h0F, 6'h23, 6'h2B: w_legal = 1'b1;
      default:             w_legal = 1'b0;
    endcase
  end

  assign w_reads_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                      (w_op == OP_BNE)   || (w_op == OP_SW);
  assign w_hazard   = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                      ((i_ex_rt == w_rs) || (w_reads_rt && (i_ex_rt == w_rt)));
  assign w_is_jump  = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_taken    = w_is_jump ||
                      ((w_op == OP_BEQ) && (i_rs_data == i_rt_data)) ||
                      ((w_op == OP_BNE) && (i_rs_data != i_rt_data));
  assign w_br_tgt   = i_pc_in + {{14{i_inst_in[15]}}, i_inst_in[15:0], 2'b00};
  assign w_j_tgt    = {i_pc_in[31:28], i_inst_in[25:0], 2'b00};

  assign w_run = (r_state == S_RUN) && !i_rst;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RESET;
      r_cnt   <= C_WARM;
`ifndef BRANCH_FLUSH_EN
      r_pend  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
`ifndef BRANCH_FLUSH_EN
      r_pend  <= w_pend_nx;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
`ifndef BRANCH_FLUSH_EN
    w_pend_nx  = r_pend;
`endif
    case (r_state)
      S_WARM, S_FLUSH: begin
        if (r_cnt <= 8'd1) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = 8'd0;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      S_RUN: begin
        if (w_trap) begin
`ifndef BRANCH_FLUSH_EN
          w_pend_nx = 1'b0;
`endif
          if (C_RDL != 8'd0) begin
            w_state_nx = S_FLUSH;
            w_cnt_nx   = C_RDL;
          end
        end else if (w_issue) begin
`ifdef BRANCH_FLUSH_EN
          if (w_taken && (C_RDL != 8'd0)) begin
            w_state_nx = S_FLUSH;
            w_cnt_nx   = C_RDL;
          end
`else
          // The delay slot issues first; the wrong-path fetches behind it are dropped.
          if (r_pend) begin
            w_pend_nx = 1'b0;
            if (C_RDL_SLOT != 8'd0) begin
              w_state_nx = S_FLUSH;
              w_cnt_nx   = C_RDL_SLOT;
            end
          end else if (w_taken) begin
            w_pend_nx = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_nx = S_RESET;
        w_cnt_nx   = C_WARM;
      end
    endcase
  end

  // Output / event logic; priority: stall, trap, hazard, issue
  always_comb begin
    o_hold_if   = 1'b0;
    o_br        = 1'b0;
    o_pc_branch = 32'd0;
    o_except    = 1'b0;
    w_trap      = 1'b0;
    w_bubble    = 1'b0;
    w_issue     = 1'b0;
    if (w_run) begin
      if (i_ex_stall) begin
        o_hold_if = 1'b1;
      end else if (!w_legal) begin
        o_except = 1'b1;
        w_trap   = 1'b1;
      end else if (w_hazard) begin
        o_hold_if = 1'b1;
        w_bubble  = 1'b1;
      end else begin
        w_issue = 1'b1;
        if (w_taken) begin
          o_br        = 1'b1;
          o_pc_branch = w_is_jump ? w_j_tgt : w_br_tgt;
        end
      end
    end
  end

  // ID slot and EPC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_id_valid <= 1'b0;
      o_id_pc    <= 32'd0;
      o_id_inst  <= 32'd0;
      o_epc      <= 32'd0;
    end else if (w_trap) begin
      o_id_valid <= 1'b0;
      o_epc      <= i_pc_in - 32'd4;
    end else if (w_bubble) begin
      o_id_valid <= 1'b0;
    end else if (w_issue) begin
      o_id_valid <= 1'b1;
      o_id_pc    <= i_pc_in;
      o_id_inst  <= i_inst_in;
    end else if (r_state != S_RUN) begin
      o_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_fetch_rx.sv
// tb/tb_id_fetch_rx.sv - directed bench for id_fetch_rx.
// Honors BRANCH_FLUSH_EN for the post-branch sequence.
module tb_id_fetch_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, inst_in, rs_data, rt_data;
  logic        ex_mem_read, ex_stall;
  logic [4:0]  ex_rt;
  logic        hold_if, br, except, id_valid;
  logic [31:0] pc_branch, epc, id_pc, id_inst;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  id_fetch_rx dut (
    .i_clk(clk), .i_rst(rst), .i_pc_in(pc_in), .i_inst_in(inst_in),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_ex_mem_read(ex_mem_read),
    .i_ex_rt(ex_rt), .i_ex_stall(ex_stall), .o_hold_if(hold_if), .o_br(br),
    .o_pc_branch(pc_branch), .o_except(except), .o_epc(epc),
    .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_inst(id_inst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
    pc_in   = pc;
    inst_in = inst;
  endtask

  task automatic after_branch(input logic [31:0] pc);
    drive(pc, 32'h2004_0004);
    #1;
    check("after_br_br0", {31'd0, br}, 32'd0);
    check("after_br_hold0", {31'd0, hold_if}, 32'd0);
    tick();
`ifdef BRANCH_FLUSH_EN
    check("flush1_valid", {31'd0, id_valid}, 32'd0);
    drive(pc + 32'd4, 32'h2004_0004);
    tick();
    check("flush2_valid", {31'd0, id_valid}, 32'd0);
`else
    check("slot_valid", {31'd0, id_valid}, 32'd1);
    check("slot_pc", id_pc, pc);
    drive(pc + 32'd4, 32'h2004_0004);
    #1;
    check("slot_flush_hold0", {31'd0, hold_if}, 32'd0);
    tick();
    check("slot_flush_valid", {31'd0, id_valid}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; ex_mem_read = 1'b0; ex_rt = 5'd0; ex_stall = 1'b0;
    rs_data = 32'd0; rt_data = 32'd0;
    drive(32'd0, 32'd0);
    #1;
    check("rst_hold", {31'd0, hold_if}, 32'd0);
    check("rst_br", {31'd0, br}, 32'd0);
    check("rst_except", {31'd0, except}, 32'd0);
    tick(); tick();
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_epc", epc, 32'd0);

    // warm-up: two ignored cycles, then addi issues
    rst = 1'b0;
    drive(32'h4, 32'h2001_0005);
    tick(); check("warm1_valid", {31'd0, id_valid}, 32'd0);
    tick(); check("warm2_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("addi_valid", {31'd0, id_valid}, 32'd1);
    check("addi_inst", id_inst, 32'h2001_0005);
    check("addi_pc", id_pc, 32'h4);

    // load-use on rs: one bubble then issue
    ex_mem_read = 1'b1; ex_rt = 5'd1;
    drive(32'h8, 32'h0023_1020);
    #1;
    check("lu_hold", {31'd0, hold_if}, 32'd1);
    check("lu_br", {31'd0, br}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, id_valid}, 32'd0);
    check("lu_inst_kept", id_inst, 32'h2001_0005);
    ex_mem_read = 1'b0;
    #1;
    check("lu_release_hold", {31'd0, hold_if}, 32'd0);
    tick();
    check("add_valid", {31'd0, id_valid}, 32'd1);
    check("add_inst", id_inst, 32'h0023_1020);
    check("add_pc", id_pc, 32'h8);

    // load-use on rt of R-type; addi does not read rt
    ex_mem_read = 1'b1; ex_rt = 5'd3;
    #1;
    check("lu_rt_hold", {31'd0, hold_if}, 32'd1);
    ex_rt = 5'd1;
    drive(32'hC, 32'h2001_0005);
    #1;
    check("addi_rt_nohaz", {31'd0, hold_if}, 32'd0);
    tick();
    check("addi2_pc", id_pc, 32'hC);
    ex_mem_read = 1'b0;

    // beq taken, backward
    rs_data = 32'd7; rt_data = 32'd7;
    drive(32'h20, 32'h1022_FFFF);
    #1;
    check("beq_br", {31'd0, br}, 32'd1);
    check("beq_tgt", pc_branch, 32'h1C);
    check("beq_hold", {31'd0, hold_if}, 32'd0);
    tick();
    check("beq_inst", id_inst, 32'h1022_FFFF);
    after_branch(32'h24);

    drive(32'h2C, 32'h3C01_0001);
    tick();
    check("lui_inst", id_inst, 32'h3C01_0001);

    // ex_stall freezes ID and masks a taken bne
    ex_stall = 1'b1; rs_data = 32'd1; rt_data = 32'd2;
    drive(32'h30, 32'h1422_0004);
    #1;
    check("stall_hold", {31'd0, hold_if}, 32'd1);
    check("stall_br", {31'd0, br}, 32'd0);
    check("stall_tgt0", pc_branch, 32'd0);
    tick();
    check("stall_frozen_inst", id_inst, 32'h3C01_0001);
    check("stall_frozen_valid", {31'd0, id_valid}, 32'd1);
    ex_stall = 1'b0;
    #1;
    check("bne_br", {31'd0, br}, 32'd1);
    check("bne_tgt", pc_branch, 32'h40);
    tick();
    check("bne_inst", id_inst, 32'h1422_0004);
    after_branch(32'h34);

    // bne not taken
    rs_data = 32'd5; rt_data = 32'd5;
    drive(32'h50, 32'h1422_0004);
    #1;
    check("bne_nt_br", {31'd0, br}, 32'd0);
    check("bne_nt_tgt", pc_branch, 32'd0);
    tick();
    check("bne_nt_pc", id_pc, 32'h50);

    // jal keeps upper PC nibble
    drive(32'h9000_0030, 32'h0C00_0040);
    #1;
    check("jal_br", {31'd0, br}, 32'd1);
    check("jal_tgt", pc_branch, 32'h9000_0100);
    tick();
    after_branch(32'h9000_0034);

    // ex_stall masks a trap; then trap beats a load-use hazard
    ex_stall = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd1;
    drive(32'h14, 32'hFC20_0000);
    #1;
    check("stall_no_except", {31'd0, except}, 32'd0);
    tick();
    ex_stall = 1'b0;
    #1;
    check("trap_except", {31'd0, except}, 32'd1);
    check("trap_hold", {31'd0, hold_if}, 32'd0);
    tick();
    check("trap_epc", epc, 32'h10);
    check("trap_valid", {31'd0, id_valid}, 32'd0);
    ex_mem_read = 1'b0;
    drive(32'h18, 32'hFC00_0000);
    #1;
    check("flush_no_except1", {31'd0, except}, 32'd0);
    tick();
    check("trap_flush1_valid", {31'd0, id_valid}, 32'd0);
    drive(32'h1C, 32'hFC00_0000);
    #1;
    check("flush_no_except2", {31'd0, except}, 32'd0);
    tick();
    check("trap_flush2_valid", {31'd0, id_valid}, 32'd0);
    drive(32'h20, 32'h2001_0005);
    tick();
    check("post_trap_valid", {31'd0, id_valid}, 32'd1);
    check("post_trap_epc", epc, 32'h10);

    // reset during FLUSH
    drive(32'h44, 32'hFC00_0000);
    tick();
    check("trap2_epc", epc, 32'h40);
    rst = 1'b1;
    #1;
    check("rst_flush_except", {31'd0, except}, 32'd0);
    check("rst_flush_br", {31'd0, br}, 32'd0);
    tick();
    check("rst_flush_valid", {31'd0, id_valid}, 32'd0);
    check("rst_flush_epc", epc, 32'd0);
    rst = 1'b0;
    drive(32'h4, 32'h2001_0005);
    tick(); check("rewarm1_valid", {31'd0, id_valid}, 32'd0);
    tick(); check("rewarm2_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("rewarm_issue_valid", {31'd0, id_valid}, 32'd1);
    check("rewarm_issue_pc", id_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
